prog_sequencer: RTL and testbench

- Parametrised fetch/sequencing controller for the 9-bit-instruction CPU. Successor to the bare program counter plus done wiring.
- Owns the program counter and a req/done handshake FSM.
- Selects one of NPROG program entry points and counts executed cycles.
- Enforces a cycle-limit watchdog, and gates core state writes through run_en so the datapath only commits while a program is running.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/cycle_watchdog.sv | 18 +
 rtl/prog_sequencer.sv | 76 +++++++
 tb/tb_prog_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and default widths for the 9-bit-instruction CPU fetch path.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} seq_state_t;
  localparam int D_DEF = 10;
  localparam int CW_DEF = 16;
endpackage

// File: rtl/cycle_watchdog.sv
// cycle_watchdog: per-run executed-cycle counter with terminal-count flag.
module cycle_watchdog #(
  parameter int CW = 16,
  parameter int MAX_CYCLES = 60000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);
  assign last = count == CW'(MAX_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= count + CW'(1);
endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: program counter and req/done run controller with watchdog and write gating.
module prog_sequencer
  import cpu_pkg::*;
#(
  parameter int D = D_DEF,
  parameter int NPROG = 4,
  parameter int PROG_STRIDE = 256,
  parameter int CW = CW_DEF,
  parameter int MAX_CYCLES = 60000,
  localparam int SW = NPROG > 1 ? $clog2(NPROG) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [SW-1:0] prog_sel,
  input  logic          halt,
  input  logic          absjump_en,
  input  logic          branch_taken,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          run_en,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] cycle_count
);
  seq_state_t state;
  logic [D-1:0] entry;
  logic sel_ok, start, last;
  assign sel_ok = int'(prog_sel) < NPROG;
  assign start = state == IDLE && req && sel_ok;
  cycle_watchdog #(.CW(CW), .MAX_CYCLES(MAX_CYCLES)) u_wd (
    .clk(clk),
    .reset(reset),
    .clear(start),
    .en(state == RUN),
    .count(cycle_count),
    .last(last)
  );
  // run_en/done are set on the transition into RUN/FIN so they stay registered.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      prog_ctr <= '0;
      entry <= '0;
      run_en <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else
      case (state)
        IDLE:
          if (req) begin
            state <= sel_ok ? LOAD : FIN;
            done <= !sel_ok;
            err <= !sel_ok;
            entry <= sel_ok ? D'(int'(prog_sel) * PROG_STRIDE) : entry;
          end
        LOAD: begin
          state <= RUN;
          prog_ctr <= entry;
          run_en <= 1'b1;
        end
        RUN:
          if (halt || last) begin
            state <= FIN;
            run_en <= 1'b0;
            done <= 1'b1;
            err <= !halt;
          end else prog_ctr <= (absjump_en && branch_taken) ? target : prog_ctr + D'(1);
        FIN:
          if (!req) begin
            state <= IDLE;
            done <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed and randomized checks of prog_sequencer against a behavioural model.
module tb_prog_sequencer;
  localparam int D = 10, NPROG = 3, STRIDE = 256, CW = 16, MAXC = 20;
  logic clk = 0, reset = 1, req = 0, halt = 0, absjump_en = 0, branch_taken = 0;
  logic [1:0] prog_sel = 0;
  logic [D-1:0] target = 0;
  logic [D-1:0] prog_ctr;
  logic run_en, done, err;
  logic [CW-1:0] cycle_count;
  int checks = 0, errors = 0;
  int m_st, m_pc, m_cnt, m_err, m_entry;

  prog_sequencer #(.D(D), .NPROG(NPROG), .PROG_STRIDE(STRIDE), .CW(CW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .halt(halt),
    .absjump_en(absjump_en), .branch_taken(branch_taken), .target(target),
    .prog_ctr(prog_ctr), .run_en(run_en), .done(done), .err(err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model phases: 0 idle, 1 load, 2 run, 3 finished.
  task automatic model_reset();
    m_st = 0; m_pc = 0; m_cnt = 0; m_err = 0; m_entry = 0;
  endtask

  task automatic model_step();
    int c;
    case (m_st)
      0: if (req) begin
           if (int'(prog_sel) < NPROG) begin
             m_st = 1; m_entry = int'(prog_sel) * STRIDE; m_cnt = 0; m_err = 0;
           end else begin
             m_st = 3; m_err = 1;
           end
         end
      1: begin m_pc = m_entry; m_st = 2; end
      2: begin
           c = m_cnt;
           m_cnt = m_cnt + 1;
           if (halt) m_st = 3;
           else if (c == MAXC - 1) begin m_st = 3; m_err = 1; end
           else if (absjump_en && branch_taken) m_pc = int'(target);
           else m_pc = (m_pc + 1) % (1 << D);
         end
      default: if (!req) m_st = 0;
    endcase
  endtask

  task automatic compare();
    chk("prog_ctr", int'(prog_ctr), m_pc);
    chk("run_en", int'(run_en), int'(m_st == 2));
    chk("done", int'(done), int'(m_st == 3));
    chk("err", int'(err), m_err);
    chk("cycle_count", int'(cycle_count), m_cnt);
  endtask

  // One clock: model advances on the edge, outputs checked 1ns later, returns at the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!reset) model_step();
    #1 compare();
    @(negedge clk);
  endtask

  task automatic start(input int sel);
    req = 1; prog_sel = 2'(sel);
    cyc(); cyc();
  endtask

  initial begin
    model_reset();
    @(negedge clk); @(negedge clk);
    compare();
    chk("reset_pc", int'(prog_ctr), 0);
    chk("reset_done", int'(done), 0);
    reset = 0;
    // Basic run from program 1, halt on 5th RUN cycle
    start(1);
    for (int i = 0; i < 5; i++) begin
      chk("basic_pc", int'(prog_ctr), 256 + i);
      halt = (i == 4);
      cyc();
    end
    halt = 0;
    chk("basic_done", int'(done), 1);
    chk("basic_cnt", int'(cycle_count), 5);
    chk("basic_err", int'(err), 0);
    chk("basic_pc_hold", int'(prog_ctr), 260);
    req = 0; cyc();
    chk("basic_done_fall", int'(done), 0);
    // Branch taken / not taken; req drop mid-run is ignored
    start(0);
    req = 0;
    repeat (3) cyc();
    chk("br_pc3", int'(prog_ctr), 3);
    absjump_en = 1; branch_taken = 1; target = 40; cyc();
    chk("br_taken", int'(prog_ctr), 40);
    branch_taken = 0; target = 99; cyc();
    chk("br_not_taken", int'(prog_ctr), 41);
    chk("br_model_pc", m_pc, 41);
    absjump_en = 0; halt = 1; cyc(); halt = 0; cyc();
    // Watchdog expiry
    start(2);
    repeat (MAXC) cyc();
    chk("wd_err", int'(err), 1);
    chk("wd_cnt", int'(cycle_count), MAXC);
    chk("wd_pc", int'(prog_ctr), 512 + MAXC - 1);
    chk("wd_model_cnt", m_cnt, MAXC);
    req = 0; cyc();
    chk("idle_keeps_err", int'(err), 1);
    chk("idle_keeps_cnt", int'(cycle_count), MAXC);
    // Halt coinciding with last allowed cycle
    start(2);
    repeat (MAXC - 1) cyc();
    halt = 1; cyc(); halt = 0;
    chk("wd_halt_err", int'(err), 0);
    chk("wd_halt_cnt", int'(cycle_count), MAXC);
    req = 0; cyc();
    // Bad program select
    req = 1; prog_sel = 3; cyc();
    chk("bad_done", int'(done), 1);
    chk("bad_err", int'(err), 1);
    chk("bad_run_en", int'(run_en), 0);
    chk("bad_pc", int'(prog_ctr), 512 + MAXC - 1);
    req = 0; cyc();
    // Asynchronous reset mid-run, then restart with req still high
    start(0);
    repeat (7) cyc();
    chk("rst_pre_pc", int'(prog_ctr), 7);
    #2 reset = 1;
    #1 chk("arst_pc", int'(prog_ctr), 0);
    chk("arst_run_en", int'(run_en), 0);
    chk("arst_done", int'(done), 0);
    model_reset();
    compare();
    cyc();
    reset = 0;
    cyc(); cyc();
    chk("rst_restart_run", int'(run_en), 1);
    // Holding req in FIN does not restart
    halt = 1; cyc(); halt = 0;
    repeat (3) begin
      cyc();
      chk("fin_hold_done", int'(done), 1);
    end
    req = 0; cyc();
    // Counter wrap past 2**D-1
    start(0);
    absjump_en = 1; branch_taken = 1; target = 10'd1021; cyc();
    absjump_en = 0;
    repeat (4) cyc();
    chk("wrap_pc", int'(prog_ctr), 1);
    halt = 1; cyc(); halt = 0; req = 0; cyc();
    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(7) == 0) req = ~req;
      prog_sel = 2'($urandom_range(3));
      halt = ($urandom_range(24) == 0);
      absjump_en = $urandom_range(3) == 0;
      branch_taken = 1'($urandom_range(1));
      target = $urandom_range(1) ? D'($urandom_range(1023)) : D'($urandom_range(1023, 1018));
      if ($urandom_range(400) == 0) begin
        #2 reset = 1;
        #1 model_reset();
        compare();
        cyc();
        reset = 0;
      end else cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
